// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Fetch entries carry the byte address together with the instruction word fetched from it.
package ifu_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;
  localparam logic [XLEN-1:0] INST_ALIGN_MASK = 32'hFFFF_FFFC;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  // Instructions are word aligned, so the two low address bits are always dropped.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return addr & INST_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_fetch_queue.sv
// Synchronous FIFO that holds fetched {pc, inst} pairs on their way to decode.
// A flush empties the queue and takes priority over a push in the same cycle.
module fetch_queue
  import ifu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count,
  output fetch_entry_t           head,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_pop;
  logic           full;

  assign empty  = (count == '0);
  assign full   = (count == (AW+1)'(DEPTH));
  assign do_pop = pop && !empty;
  assign head   = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush && push) mem[wr_ptr] <= push_data;
  end

  // The credit check at issue time must make this impossible.
  overflow_chk : assert property (@(posedge clk) disable iff (rst || flush)
                                  !(push && full && !pop));

endmodule

// File: rtl/instruction_fetch_unit.sv
// Owns the PC, issues one instruction-memory read per cycle while queue credit remains,
// and delivers {PC, instruction} pairs to decode under a valid/ready handshake.
module instruction_fetch_unit
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          FQ_DEPTH = 4
) (
  input  logic        Clk,
  input  logic        Rst,
  output logic [31:0] ImemAddr,
  input  logic [31:0] ImemInst,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  output logic        OutValid,
  input  logic        OutReady,
  output logic [31:0] OutInst,
  output logic [31:0] OutPC
);

  localparam int CW = $clog2(FQ_DEPTH) + 1;

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] inflight_pc_q;
  logic            inflight_q;
  logic [CW-1:0]   count;
  logic [CW:0]     credits_used;
  logic            issue;
  logic            push;
  logic            pop;
  logic            empty;
  fetch_entry_t    push_data;
  fetch_entry_t    head;

  // A read in flight already owns a queue slot, so it is counted against the depth.
  assign credits_used = {1'b0, count} + {{CW{1'b0}}, inflight_q};
  assign issue        = !Redirect && (credits_used < (CW+1)'(FQ_DEPTH));

  assign push           = inflight_q && !Redirect;
  assign pop            = OutValid && OutReady;
  assign push_data.pc   = inflight_pc_q;
  assign push_data.inst = ImemInst;

  assign ImemAddr = pc_q;
  assign OutValid = !empty;
  assign OutInst  = empty ? '0 : head.inst;
  assign OutPC    = empty ? '0 : head.pc;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else if (Redirect) begin
      pc_q          <= align_pc(RedirectPC);
      inflight_q    <= 1'b0;
    end else if (issue) begin
      pc_q          <= pc_q + PC_STEP;
      inflight_q    <= 1'b1;
      inflight_pc_q <= pc_q;
    end else begin
      inflight_q    <= 1'b0;
    end
  end

  fetch_queue #(
    .DEPTH (FQ_DEPTH)
  ) u_fetch_queue (
    .clk       (Clk),
    .rst       (Rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (Redirect),
    .count     (count),
    .head      (head),
    .empty     (empty)
  );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios plus randomized traffic
// checked against an in-order expected-PC stream model.
module tb_instruction_fetch_unit;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] RESET_PC2 = 32'hFFFF_FFF8;
  localparam int          FQ_DEPTH  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirectPc = '0;
  logic        outReady = 1'b1;
  logic [31:0] imemAddr, imemInst, outInst, outPc;
  logic        outValid;
  logic [31:0] imemAddr2, imemInst2, outInst2, outPc2;
  logic        outValid2;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] memSalt = '0;

  logic [31:0] expPc, expPc2, addrExp;
  int          quiet = 0;
  int          quiet2 = 0;
  bit          addrExpValid = 0;

  always #5 clk = ~clk;

  instruction_fetch_unit #(.RESET_PC(RESET_PC), .FQ_DEPTH(FQ_DEPTH)) dut (
    .Clk(clk), .Rst(rst), .ImemAddr(imemAddr), .ImemInst(imemInst),
    .Redirect(redirect), .RedirectPC(redirectPc), .OutValid(outValid),
    .OutReady(outReady), .OutInst(outInst), .OutPC(outPc)
  );

  instruction_fetch_unit #(.RESET_PC(RESET_PC2), .FQ_DEPTH(FQ_DEPTH)) dut2 (
    .Clk(clk), .Rst(rst), .ImemAddr(imemAddr2), .ImemInst(imemInst2),
    .Redirect(1'b0), .RedirectPC(32'h0), .OutValid(outValid2),
    .OutReady(1'b1), .OutInst(outInst2), .OutPC(outPc2)
  );

  // Memory holds word index (optionally salted) at every word address; one-cycle read latency.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a >> 2) ^ memSalt;
  endfunction

  always @(posedge clk) begin
    imemInst  <= memWord(imemAddr);
    imemInst2 <= memWord(imemAddr2);
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic rd, input logic [31:0] rpc, input logic rdy);
    rst        = r;
    redirect   = rd;
    redirectPc = rpc;
    outReady   = rdy;
  endtask

  // Stream rules: the visible head is always the next PC owed to decode; after a restart
  // the queue is empty for two cycles and valid on the third.
  task automatic checkStream();
    if (addrExpValid) checkOutput("imem_addr_restart", imemAddr, addrExp);
    if (quiet == 1 || quiet == 2) checkOutput("valid_refill", {31'b0, outValid}, 32'd0);
    else if (quiet == 3)          checkOutput("valid_latency", {31'b0, outValid}, 32'd1);
    if (outValid === 1'b1) begin
      checkOutput("out_pc", outPc, expPc);
      checkOutput("out_inst", outInst, memWord(expPc));
    end
    if (quiet2 == 1 || quiet2 == 2) checkOutput("valid2_refill", {31'b0, outValid2}, 32'd0);
    else if (quiet2 == 3)           checkOutput("valid2_latency", {31'b0, outValid2}, 32'd1);
    if (outValid2 === 1'b1) begin
      checkOutput("out_pc2", outPc2, expPc2);
      checkOutput("out_inst2", outInst2, memWord(expPc2));
    end
  endtask

  task automatic tick();
    logic xfer, xfer2;
    xfer  = outValid && outReady;
    xfer2 = outValid2;
    @(posedge clk);
    #1;
    addrExpValid = 0;
    if (rst) begin
      expPc = RESET_PC; quiet = 1; addrExpValid = 1; addrExp = RESET_PC;
    end else if (redirect) begin
      expPc = redirectPc & 32'hFFFF_FFFC; quiet = 1; addrExpValid = 1; addrExp = expPc;
    end else begin
      if (xfer === 1'b1) expPc = expPc + 32'd4;
      if (quiet < 100) quiet++;
    end
    if (rst) begin
      expPc2 = RESET_PC2; quiet2 = 1;
    end else begin
      if (xfer2 === 1'b1) expPc2 = expPc2 + 32'd4;
      if (quiet2 < 100) quiet2++;
    end
    checkStream();
  endtask

  task automatic restartCheck();
    applyStimulus(1, 0, 0, 1);
    tick();
    checkOutput("rst_valid", {31'b0, outValid}, 32'd0);
    checkOutput("rst_inst", outInst, 32'h0);
    checkOutput("rst_pc", outPc, 32'h0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("c0_addr", imemAddr, RESET_PC);
    tick();
    tick();
    for (int k = 0; k < 8; k++) begin
      checkOutput("stream_valid", {31'b0, outValid}, 32'd1);
      checkOutput("stream_pc", outPc, RESET_PC + 32'(4 * k));
      checkOutput("stream_inst", outInst, 32'(k));
      if (k < 4) checkOutput("wrap_pc", outPc2, RESET_PC2 + 32'(4 * k));
      tick();
    end
  endtask

  initial begin
    // Power-on reset and streaming; second instance exercises PC wraparound.
    restartCheck();

    // Stall decode long enough to fill the queue, then drain in order.
    applyStimulus(1, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0);
    repeat (10) tick();
    checkOutput("stall_addr", imemAddr, RESET_PC + 32'(4 * FQ_DEPTH));
    checkOutput("stall_pc", outPc, RESET_PC);
    applyStimulus(0, 0, 0, 1);
    for (int k = 0; k < 8; k++) begin
      checkOutput("drain_valid", {31'b0, outValid}, 32'd1);
      checkOutput("drain_pc", outPc, RESET_PC + 32'(4 * k));
      tick();
    end

    // Redirect while a transfer and a capture happen in the same cycle.
    applyStimulus(1, 0, 0, 1);
    tick();
    applyStimulus(0, 0, 0, 1);
    repeat (6) tick();
    checkOutput("redir_xfer_live", {31'b0, outValid}, 32'd1);
    applyStimulus(0, 1, 32'h0000_0103, 1);
    tick();
    applyStimulus(0, 0, 0, 1);
    checkOutput("redir_addr", imemAddr, 32'h0000_0100);
    checkOutput("redir_empty", {31'b0, outValid}, 32'd0);
    tick();
    tick();
    checkOutput("redir_valid", {31'b0, outValid}, 32'd1);
    checkOutput("redir_pc", outPc, 32'h0000_0100);
    tick();
    checkOutput("redir_pc_next", outPc, 32'h0000_0104);

    // Reset beats a simultaneous redirect with a full queue.
    applyStimulus(0, 0, 0, 0);
    repeat (10) tick();
    applyStimulus(1, 1, 32'h0000_0200, 0);
    tick();
    checkOutput("rst_redir_valid", {31'b0, outValid}, 32'd0);
    checkOutput("rst_redir_addr", imemAddr, RESET_PC);
    restartCheck();

    // Randomized traffic against the stream model.
    memSalt = $urandom;
    applyStimulus(1, 0, 0, 1);
    tick();
    for (int i = 0; i < 5000; i++) begin
      applyStimulus($urandom_range(999) == 0, $urandom_range(39) == 0, $urandom,
                    $urandom_range(3) != 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
